// File: rtl/prog_loader.sv
// Byte-stream program loader: frames of HEADER, N, 2N instruction bytes are assembled into
// 16-bit words and written to program memory while the CPU is held. Option: LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int          ADDR_W    = 8,
  parameter int          BASE_ADDR = 0,
  parameter logic [7:0]  HEADER    = 8'hA5,
  parameter int          OP_MAX    = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [15:0]       prog_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_HI, S_LO, S_CHECK, S_FIN, S_ABORT
  } state_t;

  localparam logic [4:0]        OP_MAX_L = 5'(OP_MAX);
  localparam logic [ADDR_W-1:0] BASE_L   = ADDR_W'(BASE_ADDR);

  state_t            r_state, w_next;
  logic [7:0]        r_cnt;
  logic [7:0]        r_hi;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_data;
  logic              r_we;
  logic              r_hold;

  logic              w_xfer;
  logic              w_oob;
  logic              w_op_bad;
  logic [31:0]       w_end;

  assign w_xfer   = in_valid & in_ready;
  // Frame must fit between BASE_ADDR and the top of the address space.
  assign w_end    = 32'(BASE_ADDR) + {24'd0, in_data};
  assign w_oob    = w_end > (32'd1 << ADDR_W);
  assign w_op_bad = in_data[7:3] > OP_MAX_L;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_xsum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xsum <= 8'h00;
    end else if (w_xfer) begin
      if (r_state == S_IDLE && in_data == HEADER) r_xsum <= 8'h00;
      else if (r_state == S_HI || r_state == S_LO) r_xsum <= r_xsum ^ in_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_xfer && in_data == HEADER) w_next = S_COUNT;
      S_COUNT: if (w_xfer) w_next = (in_data == 8'd0 || w_oob) ? S_ABORT : S_HI;
      S_HI:    if (w_xfer) w_next = w_op_bad ? S_ABORT : S_LO;
      S_LO: begin
        if (w_xfer) begin
`ifdef LOADER_CHECKSUM_EN
          w_next = (r_cnt == 8'd1) ? S_CHECK : S_HI;
`else
          w_next = (r_cnt == 8'd1) ? S_FIN : S_HI;
`endif
        end
      end
      S_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        if (w_xfer) w_next = (in_data == r_xsum) ? S_FIN : S_ABORT;
`else
        w_next = S_IDLE;
`endif
      end
      S_FIN:   w_next = S_IDLE;
      S_ABORT: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The word is written one cycle after its LO byte; the address advances on that write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 8'd0;
      r_hi   <= 8'd0;
      r_addr <= BASE_L;
      r_data <= 16'd0;
      r_we   <= 1'b0;
      r_hold <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (r_we) r_addr <= r_addr + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_xfer && in_data == HEADER) begin
            r_hold <= 1'b1;
            r_addr <= BASE_L;
          end
        end
        S_COUNT: if (w_xfer) r_cnt <= in_data;
        S_HI:    if (w_xfer) r_hi <= in_data;
        S_LO: begin
          if (w_xfer) begin
            r_data <= {r_hi, in_data};
            r_we   <= 1'b1;
            r_cnt  <= r_cnt - 8'd1;
          end
        end
        S_FIN:   r_hold <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state != S_FIN) && (r_state != S_ABORT);
  assign prog_we   = r_we;
  assign prog_addr = r_addr;
  assign prog_data = r_data;
  assign cpu_hold  = r_hold;
  assign done      = (r_state == S_FIN);
  assign err       = (r_state == S_ABORT);

endmodule
